uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - UART receiver: consumes the serial line driven by uart_tx (8N1, LSB first, idle high).
// - Produces one parallel byte per frame, with a single-cycle valid strobe.
// - Bit timing comes from an external clock_divider clk_en tick at OVERSAMPLE x baud rate.
// - Shares the tx block's frame format; used for board-level loopback and host command input.
// PARAMETERS
// OVERSAMPLE  16  clk_en ticks per bit period; even, >= 4
// DATA_BITS   8   data bits per frame (1..8)
// PORTS
// clk        in   1          system clock; all logic on rising edge
// rst        in   1          synchronous, active-high reset
// clk_en     in   1          oversample tick, 1-clk pulse at OVERSAMPLE x baud
// rx         in   1          asynchronous serial input, idle high
// data       out  DATA_BITS  last received byte; held until the next good frame
// valid      out  1          1-clk pulse: data updated with a good frame
// frame_err  out  1          1-clk pulse: stop bit sampled low, frame discarded
// busy       out  1          high from start-edge detect until return to IDLE
// BEHAVIOUR
// - rx passes through a 2-FF synchronizer (preset to 1) before use.
//   All further timing is counted from the synchronized signal.
// - Reset (rst=1 at a clk edge):
//   state=IDLE; data=0; valid=0; frame_err=0; busy=0; sync FFs=1; counters=0.
//   This applies mid-frame too: the partial frame is dropped, with no valid and no frame_err.
// - All state and counter updates occur only on clk edges where clk_en=1.
//   Exception: valid and frame_err clear on the next clk edge regardless of clk_en.
// - States: IDLE -> START -> DATA -> STOP -> IDLE.
// - IDLE: tick with rx_sync=0 and the previous sampled rx_sync=1 (falling edge) -> START.
//   Clear tick counter; busy=1. A line stuck low never starts a frame.
// - START: at the OVERSAMPLE/2-th tick after the edge (mid start bit):
//   - rx_sync=1 -> false start: IDLE, busy=0, no strobes.
//   - rx_sync=0 -> DATA, bit index=0, tick counter=0.
// - DATA: every OVERSAMPLE ticks, sample rx_sync into shift reg bit [index], LSB first.
//   After DATA_BITS samples -> STOP.
// - STOP: OVERSAMPLE ticks later, sample the stop bit:
//   - 1 -> data<=shift reg; valid=1 for exactly one clk.
//   - 0 -> frame_err=1 for one clk; data unchanged.
//   - Either case -> IDLE, busy=0 in the same cycle as the strobe.
// - Frame-error recovery: after a frame error (line held low/break), IDLE requires
//   rx_sync to be seen high before the next start edge is accepted.
// - Latency: valid rises on the clk edge of the stop-sample tick.
//   That tick is about 2 clk (sync) + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks
//   after the rx falling edge.
// - Back-to-back frames: a start edge arriving in the half bit after the stop sample
//   must be detected, with no frame lost.
// - valid and frame_err are never high together.
// - Counters wrap cleanly; the tick counter width is $clog2(OVERSAMPLE).
// TESTING (OVERSAMPLE=16, clk_en tied high unless noted, bit period = 16 clk)
// - Send 0xC0 8N1 -> valid pulses once, data=0xC0, frame_err=0.
//   busy=0 within 1 clk of valid.
// - Glitch: rx low for 4 clk, then high -> no valid/frame_err; busy high about 8 ticks, then 0.
// - Stop bit driven 0 on byte 0x3C -> frame_err pulses once; valid=0; data keeps prior value.
//   Then hold rx low 40 clk -> no new frame until rx returns high.
// - Back-to-back 0x55, 0xAA with zero idle gap -> two valid pulses, data 0x55 then 0xAA.
// - rst=1 during bit 3 of 0xFF -> next clk busy=0, valid=0.
//   Following frame 0x81 is received correctly.
// - Loopback with uart_tx, both on clock_divider ticks (rx tick at 16x tx baud):
//   bytes 0x00, 0xFF, 0xA5 -> received identically, in order.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, oversampled by an external clk_en tick.
//
// Parameters:
//   OVERSAMPLE  clk_en ticks per bit period (even, >= 4)
//   DATA_BITS   data bits per frame (1..8)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   clk_en     oversample tick, one clk wide, OVERSAMPLE x baud
//   rx         asynchronous serial input, idle high
//   data       last good byte, held until the next good frame
//   valid      one-clk strobe: data updated
//   frame_err  one-clk strobe: stop bit sampled low, frame discarded
//   busy       high from start-edge detect until return to IDLE
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_sync, rx_prev, rx_prev_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 valid_n, ferr_n;

    assign busy = state != IDLE;

    // The synchronizer and strobes run every clk; everything else only moves
    // on ticks because the next-state logic holds values when clk_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_prev_n;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // rx_prev is the line as seen on the previous tick. A start needs a
    // high-to-low transition between ticks, so a line held low after a
    // framing error cannot retrigger until it has been seen high again.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        data_n    = data;
        rx_prev_n = rx_prev;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        if (clk_en) begin
            rx_prev_n = rx_sync;
            case (state)
                IDLE: begin
                    if (!rx_sync && rx_prev) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        state_n = rx_sync ? IDLE : DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt_n        = '0;
                        shreg_n[idx] = rx_sync;
                        idx_n        = idx + 1'b1;
                        state_n      = idx == LAST_IDX ? STOP : DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        valid_n = rx_sync;
                        ferr_n  = !rx_sync;
                        data_n  = rx_sync ? shreg : data;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
